// File: rtl/stage_memory_access.sv
// -----------------------------------------------------------------------------
// stage_memory_access
//
// MEM pipeline stage. Takes the EX/MEM register outputs, performs loads and
// stores over a simple req/ack data bus, and registers the MEM/WB boundary.
// Upstream stages are stalled while a bus access is outstanding. Misaligned
// accesses, illegal widths and bus timeouts are reported as exceptions that
// travel with the instruction into WB.
//
// Handshake: o_BusReq is registered and, once raised, o_BusWe/o_BusAddr/
// o_BusByteEn/o_BusWData stay constant until the cycle in which i_BusAck is
// sampled high (or the access times out). The transfer completes in that ack
// cycle; o_BusReq drops on the following edge. i_BusAck is ignored while
// o_BusReq is low.
//
// Ports
//   i_Clock, i_Reset      clock; synchronous active-high reset
//   i_Valid .. i_rs2Value EX/MEM register contents (held by upstream on o_Stall)
//   o_Stall               combinational stall request to upstream stages
//   o_Bus* / i_Bus*       data bus request/response
//   o_WB_*                MEM/WB register contents
//   o_Exception/Cause     one-cycle exception pulse aligned with o_WB_Valid
//                         (01 misaligned, 10 bus timeout, 11 illegal width)
//   o_DebugState          current FSM state (0 = IDLE, 1 = WAIT)
// -----------------------------------------------------------------------------
module stage_memory_access #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Valid,
   input  logic        i_MemRead,
   input  logic        i_MemWrite,
   input  logic [2:0]  i_Funct3,
   input  logic        i_RegWrite,
   input  logic [4:0]  i_rd,
   input  logic [31:0] i_AluOutput,
   input  logic [31:0] i_rs2Value,
   output logic        o_Stall,
   output logic        o_BusReq,
   output logic        o_BusWe,
   output logic [29:0] o_BusAddr,
   output logic [3:0]  o_BusByteEn,
   output logic [31:0] o_BusWData,
   input  logic        i_BusAck,
   input  logic [31:0] i_BusRData,
   output logic        o_WB_Valid,
   output logic        o_WB_RegWrite,
   output logic [4:0]  o_WB_rd,
   output logic [31:0] o_WB_Result,
   output logic        o_Exception,
   output logic [1:0]  o_ExceptionCause,
   output logic        o_DebugState
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;

   logic          bus_req_q, bus_req_d;
   logic          bus_we_q, bus_we_d;
   logic [29:0]   bus_addr_q, bus_addr_d;
   logic [3:0]    bus_be_q, bus_be_d;
   logic [31:0]   bus_wdata_q, bus_wdata_d;

   logic          wb_valid_q, wb_valid_d;
   logic          wb_regwrite_q, wb_regwrite_d;
   logic [4:0]    wb_rd_q, wb_rd_d;
   logic [31:0]   wb_result_q, wb_result_d;
   logic          exc_q, exc_d;
   logic [1:0]    exc_cause_q, exc_cause_d;

   // Decode of the instruction sitting in EX/MEM
   logic          mem_op;
   logic          illegal_width;
   logic          misaligned;
   logic          legal_mem_op;
   logic          ack_seen;
   logic          timeout_hit;
   logic [1:0]    a_lo;

   assign a_lo          = i_AluOutput[1:0];
   assign mem_op        = i_Valid && (i_MemRead || i_MemWrite);
   assign illegal_width = (i_Funct3 == 3'b011) || (i_Funct3 == 3'b110) ||
                          (i_Funct3 == 3'b111);
   // Illegal width takes priority, so misalignment is only judged for B/H/W.
   assign misaligned    = !illegal_width &&
                          (((i_Funct3[1:0] == 2'b01) && a_lo[0]) ||
                           ((i_Funct3[1:0] == 2'b10) && (a_lo != 2'b00)));
   assign legal_mem_op  = mem_op && !illegal_width && !misaligned;
   assign ack_seen      = i_BusAck && bus_req_q;
   // An ack in the final wait cycle wins over the timeout.
   assign timeout_hit   = (state_q == ST_WAIT) && !ack_seen &&
                          (count_q == CW'(TIMEOUT_CYCLES - 1));

   // Store lane steering
   logic [31:0] st_wdata;
   logic [3:0]  st_be;

   always_comb begin
      st_wdata = i_rs2Value;
      st_be    = 4'b1111;
      case (i_Funct3[1:0])
         2'b00: begin
            st_wdata = {4{i_rs2Value[7:0]}};
            st_be    = 4'b0001 << a_lo;
         end
         2'b01: begin
            st_wdata = {2{i_rs2Value[15:0]}};
            st_be    = 4'b0011 << {a_lo[1], 1'b0};
         end
         default: begin
            st_wdata = i_rs2Value;
            st_be    = 4'b1111;
         end
      endcase
   end

   // Load lane selection and extension. EX/MEM is held during the access,
   // so the address offset and funct3 are still valid in the ack cycle.
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   always_comb begin
      ld_byte = i_BusRData[7:0];
      case (a_lo)
         2'b00:   ld_byte = i_BusRData[7:0];
         2'b01:   ld_byte = i_BusRData[15:8];
         2'b10:   ld_byte = i_BusRData[23:16];
         default: ld_byte = i_BusRData[31:24];
      endcase
      ld_half = a_lo[1] ? i_BusRData[31:16] : i_BusRData[15:0];
      case (i_Funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = i_BusRData;
      endcase
   end

   // Next-state, bus and MEM/WB logic
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      bus_req_d     = bus_req_q;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_be_d      = bus_be_q;
      bus_wdata_d   = bus_wdata_q;
      // MEM/WB defaults to a bubble
      wb_valid_d    = 1'b0;
      wb_regwrite_d = 1'b0;
      wb_rd_d       = i_rd;
      wb_result_d   = i_AluOutput;
      exc_d         = 1'b0;
      exc_cause_d   = 2'b00;
      o_Stall       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (legal_mem_op) begin
               o_Stall     = 1'b1;
               state_d     = ST_WAIT;
               count_d     = '0;
               bus_req_d   = 1'b1;
               bus_we_d    = i_MemWrite;
               bus_addr_d  = i_AluOutput[31:2];
               bus_be_d    = i_MemWrite ? st_be : 4'b1111;
               bus_wdata_d = i_MemWrite ? st_wdata : 32'd0;
            end else if (mem_op) begin
               // Faulting access: no bus cycle, instruction retires with exception
               wb_valid_d  = 1'b1;
               exc_d       = 1'b1;
               exc_cause_d = illegal_width ? 2'b11 : 2'b01;
            end else begin
               wb_valid_d    = i_Valid;
               wb_regwrite_d = i_Valid && i_RegWrite;
            end
         end

         ST_WAIT: begin
            if (ack_seen) begin
               state_d       = ST_IDLE;
               bus_req_d     = 1'b0;
               wb_valid_d    = 1'b1;
               wb_regwrite_d = !i_MemWrite && i_RegWrite;
               wb_result_d   = i_MemWrite ? i_AluOutput : ld_data;
            end else if (timeout_hit) begin
               state_d     = ST_IDLE;
               bus_req_d   = 1'b0;
               wb_valid_d  = 1'b1;
               exc_d       = 1'b1;
               exc_cause_d = 2'b10;
            end else begin
               o_Stall = 1'b1;
               count_d = count_q + CW'(1);
            end
         end

         default: begin
            state_d   = ST_IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q       <= ST_IDLE;
         count_q       <= '0;
         bus_req_q     <= 1'b0;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= '0;
         bus_be_q      <= '0;
         bus_wdata_q   <= '0;
         wb_valid_q    <= 1'b0;
         wb_regwrite_q <= 1'b0;
         wb_rd_q       <= '0;
         wb_result_q   <= '0;
         exc_q         <= 1'b0;
         exc_cause_q   <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         bus_req_q     <= bus_req_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_be_q      <= bus_be_d;
         bus_wdata_q   <= bus_wdata_d;
         wb_valid_q    <= wb_valid_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_rd_q       <= wb_rd_d;
         wb_result_q   <= wb_result_d;
         exc_q         <= exc_d;
         exc_cause_q   <= exc_cause_d;
      end
   end

   assign o_BusReq         = bus_req_q;
   assign o_BusWe          = bus_we_q;
   assign o_BusAddr        = bus_addr_q;
   assign o_BusByteEn      = bus_be_q;
   assign o_BusWData       = bus_wdata_q;
   assign o_WB_Valid       = wb_valid_q;
   assign o_WB_RegWrite    = wb_regwrite_q;
   assign o_WB_rd          = wb_rd_q;
   assign o_WB_Result      = wb_result_q;
   assign o_Exception      = exc_q;
   assign o_ExceptionCause = exc_cause_q;
   assign o_DebugState     = state_q;

endmodule

// File: tb/tb_stage_memory_access.sv
module tb_stage_memory_access;

   logic        clk = 1'b0;
   logic        i_Reset;
   logic        i_Valid, i_MemRead, i_MemWrite, i_RegWrite;
   logic [2:0]  i_Funct3;
   logic [4:0]  i_rd;
   logic [31:0] i_AluOutput, i_rs2Value;
   logic        o_Stall, o_BusReq, o_BusWe;
   logic [29:0] o_BusAddr;
   logic [3:0]  o_BusByteEn;
   logic [31:0] o_BusWData;
   logic        i_BusAck;
   logic [31:0] i_BusRData;
   logic        o_WB_Valid, o_WB_RegWrite;
   logic [4:0]  o_WB_rd;
   logic [31:0] o_WB_Result;
   logic        o_Exception;
   logic [1:0]  o_ExceptionCause;
   logic        o_DebugState;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   stage_memory_access #(.TIMEOUT_CYCLES(4)) dut (
      .i_Clock(clk), .i_Reset(i_Reset),
      .i_Valid(i_Valid), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
      .i_Funct3(i_Funct3), .i_RegWrite(i_RegWrite), .i_rd(i_rd),
      .i_AluOutput(i_AluOutput), .i_rs2Value(i_rs2Value),
      .o_Stall(o_Stall), .o_BusReq(o_BusReq), .o_BusWe(o_BusWe),
      .o_BusAddr(o_BusAddr), .o_BusByteEn(o_BusByteEn), .o_BusWData(o_BusWData),
      .i_BusAck(i_BusAck), .i_BusRData(i_BusRData),
      .o_WB_Valid(o_WB_Valid), .o_WB_RegWrite(o_WB_RegWrite), .o_WB_rd(o_WB_rd),
      .o_WB_Result(o_WB_Result), .o_Exception(o_Exception),
      .o_ExceptionCause(o_ExceptionCause), .o_DebugState(o_DebugState)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      i_Valid    = 1'b0;
      i_MemRead  = 1'b0;
      i_MemWrite = 1'b0;
      i_RegWrite = 1'b0;
      i_BusAck   = 1'b0;
   endtask

   task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd);
      i_Valid     = 1'b1;
      i_MemRead   = rd_en;
      i_MemWrite  = wr_en;
      i_Funct3    = f3;
      i_AluOutput = addr;
      i_rs2Value  = rs2;
      i_rd        = rd;
      i_RegWrite  = 1'b1;
   endtask

   // Load with ack in the first request cycle
   task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [31:0] exp);
      exp_q.push_back(exp);
      drive(1'b1, 1'b0, f3, addr, 32'h0, 5'd7);
      #1;
      check_eq({tag, "_stall_idle"}, 32'(o_Stall), 32'd1);
      tick();
      check_eq({tag, "_req"}, 32'(o_BusReq), 32'd1);
      check_eq({tag, "_addr"}, 32'(o_BusAddr), 32'(addr[31:2]));
      check_eq({tag, "_be"}, 32'(o_BusByteEn), 32'hF);
      check_eq({tag, "_we"}, 32'(o_BusWe), 32'd0);
      check_eq({tag, "_bubble"}, 32'(o_WB_Valid), 32'd0);
      i_BusAck   = 1'b1;
      i_BusRData = rdata;
      #1;
      check_eq({tag, "_stall_ack"}, 32'(o_Stall), 32'd0);
      tick();
      set_idle();
      check_eq({tag, "_wb_valid"}, 32'(o_WB_Valid), 32'd1);
      check_eq({tag, "_result"}, o_WB_Result, exp_q.pop_front());
      check_eq({tag, "_regwrite"}, 32'(o_WB_RegWrite), 32'd1);
      check_eq({tag, "_rd"}, 32'(o_WB_rd), 32'd7);
      check_eq({tag, "_req_drop"}, 32'(o_BusReq), 32'd0);
   endtask

   // Store; the ack is withheld for one extra cycle to check field stability
   task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rs2, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
      drive(1'b0, 1'b1, f3, addr, rs2, 5'd9);
      tick();
      check_eq({tag, "_req"}, 32'(o_BusReq), 32'd1);
      check_eq({tag, "_we"}, 32'(o_BusWe), 32'd1);
      check_eq({tag, "_addr"}, 32'(o_BusAddr), 32'(addr[31:2]));
      check_eq({tag, "_be"}, 32'(o_BusByteEn), 32'(exp_be));
      check_eq({tag, "_wdata"}, o_BusWData, exp_wdata);
      check_eq({tag, "_stall_wait"}, 32'(o_Stall), 32'd1);
      tick();
      check_eq({tag, "_be_held"}, 32'(o_BusByteEn), 32'(exp_be));
      check_eq({tag, "_wdata_held"}, o_BusWData, exp_wdata);
      i_BusAck = 1'b1;
      tick();
      set_idle();
      check_eq({tag, "_wb_valid"}, 32'(o_WB_Valid), 32'd1);
      check_eq({tag, "_regwrite"}, 32'(o_WB_RegWrite), 32'd0);
      check_eq({tag, "_result"}, o_WB_Result, addr);
      check_eq({tag, "_exc"}, 32'(o_Exception), 32'd0);
   endtask

   // Access rejected without a bus cycle
   task automatic do_fault(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [1:0] exp_cause);
      drive(1'b1, 1'b0, f3, addr, 32'h0, 5'd4);
      #1;
      check_eq({tag, "_stall"}, 32'(o_Stall), 32'd0);
      tick();
      set_idle();
      check_eq({tag, "_req"}, 32'(o_BusReq), 32'd0);
      check_eq({tag, "_wb_valid"}, 32'(o_WB_Valid), 32'd1);
      check_eq({tag, "_regwrite"}, 32'(o_WB_RegWrite), 32'd0);
      check_eq({tag, "_exc"}, 32'(o_Exception), 32'd1);
      check_eq({tag, "_cause"}, 32'(o_ExceptionCause), 32'(exp_cause));
      tick();
      check_eq({tag, "_exc_pulse"}, 32'(o_Exception), 32'd0);
   endtask

   // LW with no ack until the last allowed cycle (ack_last) or never
   task automatic do_timeout(input string tag, input logic ack_last);
      drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3);
      tick();
      for (int i = 0; i < 3; i++) begin
         check_eq({tag, "_req_wait"}, 32'(o_BusReq), 32'd1);
         check_eq({tag, "_stall_wait"}, 32'(o_Stall), 32'd1);
         tick();
      end
      check_eq({tag, "_req_last"}, 32'(o_BusReq), 32'd1);
      i_BusAck   = ack_last;
      i_BusRData = 32'h1122_3344;
      #1;
      check_eq({tag, "_stall_release"}, 32'(o_Stall), 32'd0);
      tick();
      set_idle();
      check_eq({tag, "_req_drop"}, 32'(o_BusReq), 32'd0);
      check_eq({tag, "_state"}, 32'(o_DebugState), 32'd0);
      check_eq({tag, "_wb_valid"}, 32'(o_WB_Valid), 32'd1);
      if (ack_last) begin
         check_eq({tag, "_exc"}, 32'(o_Exception), 32'd0);
         check_eq({tag, "_result"}, o_WB_Result, 32'h1122_3344);
         check_eq({tag, "_regwrite"}, 32'(o_WB_RegWrite), 32'd1);
      end else begin
         check_eq({tag, "_exc"}, 32'(o_Exception), 32'd1);
         check_eq({tag, "_cause"}, 32'(o_ExceptionCause), 32'd2);
         check_eq({tag, "_regwrite"}, 32'(o_WB_RegWrite), 32'd0);
      end
   endtask

   initial begin
      // Reset
      set_idle();
      i_Funct3    = 3'b000;
      i_rd        = 5'd0;
      i_AluOutput = 32'h0;
      i_rs2Value  = 32'h0;
      i_BusRData  = 32'h0;
      i_Reset     = 1'b1;
      tick();
      tick();
      i_Reset = 1'b0;
      check_eq("rst_req", 32'(o_BusReq), 32'd0);
      check_eq("rst_wb_valid", 32'(o_WB_Valid), 32'd0);
      check_eq("rst_exc", 32'(o_Exception), 32'd0);
      check_eq("rst_state", 32'(o_DebugState), 32'd0);
      check_eq("rst_stall", 32'(o_Stall), 32'd0);

      // Non-memory pass-through (ADD)
      drive(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
      #1;
      check_eq("add_stall", 32'(o_Stall), 32'd0);
      tick();
      set_idle();
      check_eq("add_wb_valid", 32'(o_WB_Valid), 32'd1);
      check_eq("add_result", o_WB_Result, 32'h1234_5678);
      check_eq("add_rd", 32'(o_WB_rd), 32'd5);
      check_eq("add_regwrite", 32'(o_WB_RegWrite), 32'd1);
      check_eq("add_req", 32'(o_BusReq), 32'd0);

      // Loads
      do_load("lb",  32'h103, 3'b000, 32'h80FF_0000, 32'hFFFF_FF80);
      do_load("lbu", 32'h102, 3'b100, 32'h80FF_0000, 32'h0000_00FF);
      do_load("lh",  32'h100, 3'b001, 32'h1234_8001, 32'hFFFF_8001);
      do_load("lhu", 32'h102, 3'b101, 32'h80FF_0000, 32'h0000_80FF);
      do_load("lw",  32'h104, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D);

      // Stores
      do_store("sh", 32'h202, 3'b001, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF);
      do_store("sb", 32'h101, 3'b000, 32'h1234_565A, 4'b0010, 32'h5A5A_5A5A);
      do_store("sw", 32'h200, 3'b010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

      // Faults
      do_fault("lw_mis", 32'h101, 3'b010, 2'b01);
      do_fault("lh_mis", 32'h103, 3'b001, 2'b01);
      do_fault("f3_011", 32'h100, 3'b011, 2'b11);

      // Timeout and ack on the final cycle
      do_timeout("tmo", 1'b0);
      do_timeout("ack_last", 1'b1);

      // Reset while waiting on the bus
      drive(1'b0, 1'b0, 3'b000, 32'h5555_AAAA, 32'h0, 5'd11);
      tick();
      drive(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 5'd6);
      tick();
      check_eq("rstw_req_before", 32'(o_BusReq), 32'd1);
      check_eq("rstw_state_before", 32'(o_DebugState), 32'd1);
      i_Reset = 1'b1;
      tick();
      i_Reset = 1'b0;
      set_idle();
      check_eq("rstw_req", 32'(o_BusReq), 32'd0);
      check_eq("rstw_state", 32'(o_DebugState), 32'd0);
      check_eq("rstw_wb_valid", 32'(o_WB_Valid), 32'd0);
      check_eq("rstw_wb_regwrite", 32'(o_WB_RegWrite), 32'd0);
      check_eq("rstw_wb_rd", 32'(o_WB_rd), 32'd0);
      check_eq("rstw_wb_result", o_WB_Result, 32'd0);
      check_eq("rstw_exc", 32'(o_Exception), 32'd0);
      check_eq("rstw_be", 32'(o_BusByteEn), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
